tt_um_shift_lab: RTL
====================

TT_UM_SHIFT_LAB -- requirements
Module: tt_um_shift_lab

Interface
REQ-001 Parameter WIDTH, default 8, register width; legal range 4..8.
REQ-002 Parameter TAPS, default 8'hB8, LFSR feedback tap mask; bits at or above WIDTH are ignored.
REQ-003 Parameter SEED, default 8'h01, reset and lock-up recovery value, truncated to WIDTH; SHALL be non-zero.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 ena  in  1  design enable; low freezes all state.
REQ-007 ui_in  in  8  [1:0] mode, [2] serial data, [3] step strobe, [4] single-step select, [7:5] unused.
REQ-008 uio_in  in  8  parallel load value.
REQ-009 uo_out  out  8  [WIDTH-1:0] register Q; remaining bits 0.
REQ-010 uio_out  out  8  see REQ-027; otherwise all 0.
REQ-011 uio_oe  out  8  see REQ-027; otherwise all 0.

Function
REQ-012 The block SHALL hold a WIDTH-bit register R and a 1-bit strobe history S.
REQ-013 An advance SHALL occur in a cycle when ena=1 and either ui_in[4]=0, or ui_in[4]=1 and ui_in[3]=1 with S=0.
REQ-014 S SHALL load ui_in[3] on every cycle with ena=1, whether or not an advance occurs.
REQ-015 On an advance, mode 00 (HOLD) SHALL leave R unchanged.
REQ-016 On an advance, mode 01 (SHIFT) SHALL set R to {R[WIDTH-2:0], ui_in[2]}.
REQ-017 On an advance, mode 10 (LFSR) SHALL set R to {R[WIDTH-2:0], ^(R & TAPS[WIDTH-1:0])}.
REQ-018 On an advance in LFSR mode with R all-zero (lock-up), R SHALL load SEED instead of REQ-017.
REQ-019 On an advance, mode 11 (LOAD) SHALL set R to uio_in[WIDTH-1:0].
REQ-020 Without an advance, R SHALL be unchanged.
REQ-021 A mode change SHALL take effect on the first advance after it, with no extra latency.
REQ-022 uo_out SHALL be driven directly from R; an update is visible one cycle after the advancing edge.
REQ-023 In single-step mode, a strobe held high for N cycles SHALL produce exactly one advance.

Reset
REQ-024 On a clk edge with rst_n=0, the block SHALL set R=SEED and S=0, irrespective of ena.
REQ-025 Reset SHALL take priority over any advance in the same cycle; mid-sequence reset SHALL restart from SEED.
REQ-026 After reset, uo_out SHALL read SEED, zero-extended to 8 bits, and uio_out/uio_oe SHALL follow REQ-010/011 or REQ-027.

Configuration
REQ-027 With SHIFT_LAB_PARITY_EN defined, uio_out[7] SHALL equal ^R (combinational), uio_oe[7] SHALL be 1, and the load source bit 7 SHALL read as 0.
REQ-028 Without SHIFT_LAB_PARITY_EN, uio_out and uio_oe SHALL be all 0, and LOAD SHALL use all of uio_in[WIDTH-1:0].

Structure
REQ-029 The shared package shift_lab_pkg SHALL hold the mode enum (HOLD, SHIFT, LFSR, LOAD) and the default TAPS and SEED constants.
REQ-030 Strobe edge detection SHALL be a sub-module, step_edge_det (inputs clk, rst_n, ena, strobe; output rise).
REQ-031 R update logic SHALL live in the top module; no other sub-modules.

Verification
REQ-032 Reset: rst_n=0 for 2 cycles, then 1, ena=1, mode HOLD -> uo_out=8'h01 and stays there.
REQ-033 LFSR free-run: WIDTH=8, after reset, mode 10, four cycles -> uo_out 02, 04, 08, 11.
REQ-034 Lock-up: LOAD 8'h00, then LFSR advance -> uo_out=8'h01 (SEED), not 00.
REQ-035 Single-step: ui_in[4]=1, mode SHIFT, data=1, strobe high 5 cycles then low, from 01 -> uo_out=03 once only; second strobe pulse -> 07.
REQ-036 ena gating: ena=0 with strobe toggling, mode LOAD, uio_in=A5 -> uo_out unchanged; ena=1 with ui_in[4]=0 -> A5 next cycle.
REQ-037 Parity build: SHIFT_LAB_PARITY_EN, LOAD uio_in=8'hFF -> R=8'h7F, uio_oe=8'h80, uio_out[7]=1; reset mid-LFSR run -> uo_out=01 next cycle.

Source files
------------

// File: rtl/shift_lab_pkg.sv
// ============================================================================
// Module      : shift_lab_pkg
// Description : Shared mode encoding and default LFSR constants for shift_lab.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_lab_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHIFT = 2'b01,
        MODE_LFSR  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    localparam logic [7:0] c_DEFAULT_TAPS = 8'hB8;
    localparam logic [7:0] c_DEFAULT_SEED = 8'h01;

endpackage

`default_nettype wire

// File: rtl/step_edge_det.sv
// ============================================================================
// Module      : step_edge_det
// Description : Rising-edge detector for the single-step strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic strobe,
    output logic rise
);

    logic r_prev;

    // History only moves while enabled, so a frozen design cannot see a stale edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else if (ena) begin
            r_prev <= strobe;
        end
    end

    assign rise = strobe & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/tt_um_shift_lab.sv
// ============================================================================
// Module      : tt_um_shift_lab
// Description : Hold / shift / LFSR / load register with optional single-step.
//               Optional macro SHIFT_LAB_PARITY_EN exposes parity on uio[7].
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_um_shift_lab
    import shift_lab_pkg::*;
#(
    parameter int         WIDTH = 8,
    parameter logic [7:0] TAPS  = c_DEFAULT_TAPS,
    parameter logic [7:0] SEED  = c_DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [WIDTH-1:0] c_SEED_W = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_TAPS_W = TAPS[WIDTH-1:0];

    logic [WIDTH-1:0] r_q;
    mode_e            w_mode;
    logic             w_rise;
    logic             w_advance;
    logic             w_feedback;
    logic [7:0]       w_load_src;
    logic             w_unused_bits;

    step_edge_det u_step_edge_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .strobe (ui_in[3]),
        .rise   (w_rise)
    );

    assign w_mode     = mode_e'(ui_in[1:0]);
    assign w_advance  = ena & (~ui_in[4] | w_rise);
    assign w_feedback = ^(r_q & c_TAPS_W);

`ifdef SHIFT_LAB_PARITY_EN
    // uio[7] is repurposed as an output, so its input value must not leak into LOAD.
    assign w_load_src = {1'b0, uio_in[6:0]};
    assign uio_out    = {^r_q, 7'b0};
    assign uio_oe     = 8'h80;
`else
    assign w_load_src = uio_in;
    assign uio_out    = 8'h00;
    assign uio_oe     = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= c_SEED_W;
        end else if (w_advance) begin
            case (w_mode)
                MODE_HOLD:  r_q <= r_q;
                MODE_SHIFT: r_q <= {r_q[WIDTH-2:0], ui_in[2]};
                // An all-zero register would stay stuck, so it recovers from SEED.
                MODE_LFSR:  r_q <= (r_q == '0) ? c_SEED_W : {r_q[WIDTH-2:0], w_feedback};
                MODE_LOAD:  r_q <= w_load_src[WIDTH-1:0];
                default:    r_q <= r_q;
            endcase
        end
    end

    assign uo_out = 8'(r_q);

    assign w_unused_bits = ^{ui_in[7:5], uio_in};

endmodule

`default_nettype wire
